// File: rtl/spi_aes_master.sv
// spi_aes_master: initiator side of the serial AES link.
//   Accepts a parallel key and ciphertext block on a single-cycle start and
//   sends them LSB-first as one frame: block[0..127] first, then key[0..N-1].
//   After a fixed compute window it shifts in the 128-bit result and presents
//   it in parallel with a one-cycle done pulse. One transaction at a time.
// Parameters: N (key width, frame = 128+N bits), WAIT_CYCLES (>= 1, cycles
//   between the last outbound bit and the first result sample).
// Ports:
//   clk, reset      system/bit clock, synchronous active-high reset
//   start           request, honoured only in IDLE
//   key, block      operands, sampled on the accepted start cycle
//   miso            serial result from the peripheral (sampled on posedge)
//   mosi            serial data to the peripheral
//   cs_n, spi_en    frame select (active low) and peripheral enable
//   busy, done      transaction in flight / one-cycle result-valid pulse
//   result          decrypted block, held until the next completed frame
// Optional: define SPI_AES_MASTER_FRAMECNT_EN to add frame_count[15:0], a
//   wrapping count of completed frames.
module spi_aes_master #(
  parameter int unsigned N           = 128,
  parameter int unsigned WAIT_CYCLES = 22
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   key,
  input  logic [127:0]   block,
  input  logic           miso,
  output logic           mosi,
  output logic           cs_n,
  output logic           spi_en,
  output logic           busy,
  output logic           done,
  output logic [127:0]   result
`ifdef SPI_AES_MASTER_FRAMECNT_EN
  ,
  output logic [15:0]    frame_count
`endif
);

  localparam int unsigned RES_W   = 128;
  localparam int unsigned BLK_W   = 128;
  localparam int unsigned FRAME_W = BLK_W + N;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + WAIT_CYCLES + RES_W);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SHIFT_OUT, S_WAIT, S_SHIFT_IN, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [RES_W-1:0]     cap_q, cap_d;
  logic [RES_W-1:0]     result_q, result_d;
  logic                 mosi_q, mosi_d;
  logic                 cs_n_q, cs_n_d;
  logic                 spi_en_q, spi_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic so_last, wt_last, si_last;

  assign so_last = (cnt_q == CNT_W'(FRAME_W - 1));
  assign wt_last = (cnt_q == CNT_W'(WAIT_CYCLES - 1));
  assign si_last = (cnt_q == CNT_W'(RES_W - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (start)   state_d = S_PRE;
      S_PRE:                    state_d = S_SHIFT_OUT;
      S_SHIFT_OUT: if (so_last) state_d = S_WAIT;
      S_WAIT:      if (wt_last) state_d = S_SHIFT_IN;
      S_SHIFT_IN:  if (si_last) state_d = S_DONE;
      S_DONE:                   state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered pins line up with state_q
  always_comb begin
    mosi_d   = 1'b0;
    cs_n_d   = 1'b1;
    spi_en_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_d)
      S_PRE, S_WAIT, S_SHIFT_IN: begin
        cs_n_d   = 1'b0;
        spi_en_d = 1'b1;
        busy_d   = 1'b1;
      end
      S_SHIFT_OUT: begin
        cs_n_d   = 1'b0;
        spi_en_d = 1'b1;
        busy_d   = 1'b1;
        mosi_d   = shreg_q[0];
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next values
  always_comb begin
    cnt_d    = '0;
    shreg_d  = shreg_q;
    cap_d    = cap_q;
    result_d = result_q;
    // counting states only exit on their terminal count, so staying put means count on
    if ((state_d == state_q) &&
        (state_q == S_SHIFT_OUT || state_q == S_WAIT || state_q == S_SHIFT_IN))
      cnt_d = cnt_q + CNT_W'(1);
    if (state_q == S_IDLE && start)
      shreg_d = {key, block};
    else if (state_d == S_SHIFT_OUT)
      shreg_d = shreg_q >> 1;
    // first received bit ends up in bit 0 after 128 right shifts
    if (state_q == S_SHIFT_IN)
      cap_d = {miso, cap_q[RES_W-1:1]};
    if (state_q == S_SHIFT_IN && state_d == S_DONE)
      result_d = cap_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      shreg_q  <= '0;
      cap_q    <= '0;
      result_q <= '0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      spi_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      cap_q    <= cap_d;
      result_q <= result_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      spi_en_q <= spi_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign mosi   = mosi_q;
  assign cs_n   = cs_n_q;
  assign spi_en = spi_en_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

`ifdef SPI_AES_MASTER_FRAMECNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  // Completed-frame counter; wraps naturally at 16 bits
  always_comb begin
    fcnt_d = fcnt_q;
    if (state_q == S_DONE) fcnt_d = fcnt_q + 16'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) fcnt_q <= '0;
    else       fcnt_q <= fcnt_d;
  end

  assign frame_count = fcnt_q;
`endif

endmodule

// File: tb/tb_spi_aes_master.sv
`timescale 1ns/1ps
module tb_spi_aes_master;

  localparam logic [127:0] KEY_V = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_V  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_V  = 128'h00112233445566778899aabbccddeeff;
  localparam int LAT0   = 408;
  localparam int LAT1   = 544;
  localparam int BUDGET = 2000;

  logic         clk;
  logic         reset;
  logic         start0, start1;
  logic [127:0] key0, block0, block1;
  logic [255:0] key1;
  logic         miso0, miso1, mosi0, mosi1;
  logic         cs_n0, cs_n1, spi_en0, spi_en1;
  logic         busy0, busy1, done0, done1;
  logic [127:0] result0, result1;
`ifdef SPI_AES_MASTER_FRAMECNT_EN
  logic [15:0]  fc0, fc1;
  int           fc_exp0;
`endif

  int           checks;
  int           errors;
  logic [127:0] exp_q0[$];
  logic [127:0] exp_q1[$];
  logic         force_one;
  logic [511:0] mosi_tr;
  logic [511:0] csn_tr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_aes_master #(.N(128), .WAIT_CYCLES(22)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .key(key0), .block(block0),
    .miso(miso0), .mosi(mosi0), .cs_n(cs_n0), .spi_en(spi_en0),
`ifdef SPI_AES_MASTER_FRAMECNT_EN
    .frame_count(fc0),
`endif
    .busy(busy0), .done(done0), .result(result0)
  );

  spi_aes_master #(.N(256), .WAIT_CYCLES(30)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .key(key1), .block(block1),
    .miso(miso1), .mosi(mosi1), .cs_n(cs_n1), .spi_en(spi_en1),
`ifdef SPI_AES_MASTER_FRAMECNT_EN
    .frame_count(fc1),
`endif
    .busy(busy1), .done(done1), .result(result1)
  );

  // Reference peripheral behaviour: the known FIPS-197 vector decrypts to its
  // plaintext; anything else maps through a fixed order-sensitive mix.
  function automatic logic [127:0] ref_fn(input logic [383:0] fr, input int d);
    logic [127:0] blk, klo, khi;
    blk = fr[127:0];
    klo = fr[255:128];
    khi = (d == 1) ? fr[383:256] : 128'h0;
    if (d == 0 && klo == KEY_V && blk == CT_V) return PT_V;
    return blk ^ {klo[63:0], klo[127:64]} ^ {khi[0], khi[127:1]} ^
           128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  function automatic int fl(input int d);
    return (d == 0) ? 256 : 384;
  endfunction

  function automatic int wt(input int d);
    return (d == 0) ? 22 : 30;
  endfunction

  // Behavioural peripheral for both instances
  logic         cs_w [2];
  logic         mo_w [2];
  logic         mi_w [2];
  int           kcnt [2];
  logic [383:0] rx   [2];
  logic [127:0] resp [2];

  assign cs_w[0] = cs_n0;
  assign cs_w[1] = cs_n1;
  assign mo_w[0] = mosi0;
  assign mo_w[1] = mosi1;
  assign miso0   = mi_w[0];
  assign miso1   = mi_w[1];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset || cs_w[d] !== 1'b0) kcnt[d] <= 0;
      else begin
        // first low-cs edge carries the dummy lead bit
        if (kcnt[d] >= 1 && kcnt[d] <= fl(d)) rx[d][kcnt[d]-1] <= mo_w[d];
        kcnt[d] <= kcnt[d] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (kcnt[d] == fl(d) + 1)
        resp[d] <= (d == 0 && force_one) ? 128'h1 : ref_fn(rx[d], d);
      if ((kcnt[d] - 1 - fl(d) - wt(d)) >= 0 && (kcnt[d] - 1 - fl(d) - wt(d)) < 128)
        mi_w[d] <= resp[d][kcnt[d] - 1 - fl(d) - wt(d)];
      else
        mi_w[d] <= 1'b0;
    end
  end

  // Starts a dut0 frame from a negedge, runs to the done cycle, checks it.
  task automatic run_frame0(input logic [127:0] k_in, input logic [127:0] b_in,
                            input logic [127:0] exp_r, input int inj, input string nm);
    int n;
    bit seen;
    int busy_low;
    int csn_high;
    logic [127:0] e;
    exp_q0.push_back(exp_r);
    start0 = 1'b1; key0 = k_in; block0 = b_in;
    @(negedge clk);
    start0 = 1'b0;
    n = 1; seen = 0; busy_low = 0; csn_high = 0;
    mosi_tr = '0; csn_tr = '1;
    while (n <= BUDGET && !seen) begin
      if (n < 512) begin
        mosi_tr[n] = mosi0;
        csn_tr[n]  = cs_n0;
      end
      if (busy0 !== 1'b1) busy_low++;
      if (done0 === 1'b1) seen = 1;
      else begin
        if (cs_n0 !== 1'b0) csn_high++;
        start0 = (n == inj);
        if (n == inj) begin
          key0   = ~k_in;
          block0 = b_in ^ 128'hdeadbeef_00000000_cafef00d_12345678;
        end
        @(negedge clk);
        n++;
      end
    end
    start0 = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_timeout: no done within %0d cycles", nm, BUDGET); end
    checks++;
    if (n !== LAT0) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", nm, n, LAT0); end
    checks++;
    if (busy_low !== 0) begin errors++; $display("FAIL %s_busy_span: busy low in %0d cycles, expected 0", nm, busy_low); end
    checks++;
    if (csn_high !== 0) begin errors++; $display("FAIL %s_csn_continuous: cs_n high in %0d frame cycles, expected 0", nm, csn_high); end
    checks++;
    if (cs_n0 !== 1'b1) begin errors++; $display("FAIL %s_csn_done: got %b expected 1", nm, cs_n0); end
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      checks++;
      if (result0 !== e) begin errors++; $display("FAIL %s_result: got %h expected %h", nm, result0, e); end
    end
`ifdef SPI_AES_MASTER_FRAMECNT_EN
    if (seen) fc_exp0++;
`endif
  endtask

  // One cycle after done: back in IDLE
  task automatic check_idle0(input string nm);
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || cs_n0 !== 1'b1 || spi_en0 !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b done=%b cs_n=%b spi_en=%b expected 0 0 1 0",
               nm, busy0, done0, cs_n0, spi_en0);
    end
`ifdef SPI_AES_MASTER_FRAMECNT_EN
    checks++;
    if (fc0 !== 16'(fc_exp0)) begin errors++; $display("FAIL %s_frame_count: got %0d expected %0d", nm, fc0, fc_exp0); end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; force_one = 1'b0;
    key0 = '0; block0 = '0; key1 = '0; block1 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (mosi0 !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi0); end
    checks++;
    if (cs_n0 !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n0); end
    checks++;
    if (spi_en0 !== 1'b0) begin errors++; $display("FAIL reset_spi_en: got %b expected 0", spi_en0); end
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b %b expected 0 0", busy0, done0); end
    checks++;
    if (result0 !== 128'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result0); end
`ifdef SPI_AES_MASTER_FRAMECNT_EN
    fc_exp0 = 0;
    checks++;
    if (fc0 !== 16'h0) begin errors++; $display("FAIL reset_frame_count: got %0d expected 0", fc0); end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Reset sampled on the 200th edge counting the accepting edge as the first
  task automatic test_reset_mid_frame();
    start0 = 1'b1; key0 = KEY_V; block0 = CT_V;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 1; i < 199; i++) @(negedge clk);
    checks++;
    if (cs_n0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL midreset_inframe: cs_n=%b busy=%b expected 0 1", cs_n0, busy0); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cs_n0 !== 1'b1 || spi_en0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || mosi0 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: cs_n=%b spi_en=%b busy=%b done=%b mosi=%b expected 1 0 0 0 0",
               cs_n0, spi_en0, busy0, done0, mosi0);
    end
    checks++;
    if (result0 !== 128'h0) begin errors++; $display("FAIL midreset_result: got %h expected 0", result0); end
`ifdef SPI_AES_MASTER_FRAMECNT_EN
    fc_exp0 = 0;
`endif
    reset = 1'b0;
    @(negedge clk);
    run_frame0(KEY_V, CT_V, PT_V, 0, "after_reset");
    check_idle0("after_reset");
  endtask

  task automatic test_loopback();
    run_frame0(KEY_V, CT_V, ref_fn({128'h0, KEY_V, CT_V}, 0), 0, "loopback");
    checks++;
    if (result0 !== PT_V) begin errors++; $display("FAIL loopback_plaintext: got %h expected %h", result0, PT_V); end
    check_idle0("loopback");
  endtask

  task automatic test_bit_order();
    int ones;
    run_frame0(128'h0, 128'h1, ref_fn({128'h0, 128'h0, 128'h1}, 0), 0, "bitorder");
    checks++;
    if (mosi_tr[1] !== 1'b0 || csn_tr[1] !== 1'b0) begin errors++; $display("FAIL bitorder_pre: mosi=%b cs_n=%b expected 0 0", mosi_tr[1], csn_tr[1]); end
    checks++;
    if (mosi_tr[2] !== 1'b1) begin errors++; $display("FAIL bitorder_first: got %b expected 1", mosi_tr[2]); end
    ones = 0;
    for (int i = 3; i <= 257; i++) if (mosi_tr[i] !== 1'b0) ones++;
    checks++;
    if (ones !== 0) begin errors++; $display("FAIL bitorder_rest: %0d nonzero bits, expected 0", ones); end
    check_idle0("bitorder");
  endtask

  task automatic test_result_order();
    force_one = 1'b1;
    run_frame0({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
               128'h1, 0, "resorder");
    force_one = 1'b0;
    check_idle0("resorder");
  endtask

  task automatic test_start_during_busy();
    int extra;
    run_frame0(KEY_V, CT_V, PT_V, 50, "busystart");
    check_idle0("busystart");
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done0 !== 1'b0 || busy0 !== 1'b0) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL busystart_not_queued: %0d active cycles, expected 0", extra); end
    checks++;
    if (result0 !== PT_V) begin errors++; $display("FAIL busystart_result_hold: got %h expected %h", result0, PT_V); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] kb, bb;
    kb = {$urandom, $urandom, $urandom, $urandom};
    bb = {$urandom, $urandom, $urandom, $urandom};
    run_frame0(KEY_V, CT_V, PT_V, 0, "b2b_first");
    // start during DONE must be ignored
    start0 = 1'b1; key0 = kb; block0 = bb;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_done_start_ignored: busy=%b expected 0", busy0); end
    // start in the first IDLE cycle after DONE is accepted
    run_frame0(kb, bb, ref_fn({128'h0, kb, bb}, 0), 0, "b2b_second");
    check_idle0("b2b_second");
  endtask

  task automatic run_frame1(input string nm);
    int n;
    bit seen;
    logic [127:0] e;
    key1   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    block1 = {$urandom, $urandom, $urandom, $urandom};
    exp_q1.push_back(ref_fn({key1, block1}, 1));
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 1; seen = 0;
    while (n <= BUDGET && !seen) begin
      if (done1 === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (!seen || n !== LAT1) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", nm, n, LAT1); end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      checks++;
      if (result1 !== e) begin errors++; $display("FAIL %s_result: got %h expected %h", nm, result1, e); end
    end
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || cs_n1 !== 1'b1) begin errors++; $display("FAIL %s_idle: busy=%b cs_n=%b expected 0 1", nm, busy1, cs_n1); end
  endtask

  task automatic test_param_sweep();
`ifdef SPI_AES_MASTER_FRAMECNT_EN
    checks++;
    if (fc1 !== 16'd0) begin errors++; $display("FAIL sweep_fc0: got %0d expected 0", fc1); end
`endif
    run_frame1("sweep1");
`ifdef SPI_AES_MASTER_FRAMECNT_EN
    checks++;
    if (fc1 !== 16'd1) begin errors++; $display("FAIL sweep_fc1: got %0d expected 1", fc1); end
`endif
    run_frame1("sweep2");
`ifdef SPI_AES_MASTER_FRAMECNT_EN
    checks++;
    if (fc1 !== 16'd2) begin errors++; $display("FAIL sweep_fc2: got %0d expected 2", fc1); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reset_mid_frame();
    test_loopback();
    test_bit_order();
    test_result_order();
    test_start_during_busy();
    test_back_to_back();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
